// File: rtl/mpsoc_msi_wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// A grant is held for the whole cyc (bursts and stb gaps included). A response
// watchdog turns a hung slave into a one-cycle err to the granted master.
module mpsoc_msi_wb_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]          last_q, last_d;   // also the granted index while BUSY
  logic [31:0]            wd_cnt_q, wd_cnt_d;

  logic          busy, g_cyc, g_stb, resp, wd_fire;
  logic          req_found;
  logic [LW-1:0] req_idx;

  assign busy  = (state_q == BUSY);
  assign g_cyc = busy & wbm_cyc_i[last_q];
  assign g_stb = busy & wbm_stb_i[last_q];
  assign resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // Watchdog fires on the TIMEOUT-th unanswered strobe cycle; a response wins.
  assign wd_fire   = (TIMEOUT != 0) && g_cyc && g_stb && !resp &&
                     (wd_cnt_q == 32'(TIMEOUT - 1));
  assign timeout_o = wd_fire;
  assign grant_o   = grant_q;

  // Rotating search: first requester strictly after last, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    req_found = 1'b0;
    req_idx   = last_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last_q) + i) % NUM_MASTERS;
      if (!req_found && wbm_cyc_i[idx]) begin
        req_found = 1'b1;
        req_idx   = LW'(idx);
      end
    end
  end

  // Next-state: grant on any request from IDLE, release when owner drops cyc.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d = BUSY;
          grant_d = NUM_MASTERS'(1) << req_idx;
          last_d  = req_idx;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Watchdog counts unanswered strobe cycles; anything else clears it.
  always_comb begin
    wd_cnt_d = '0;
    if ((TIMEOUT != 0) && g_cyc && g_stb && !resp && !wd_fire)
      wd_cnt_d = wd_cnt_q + 32'd1;
  end

  // State, grant, rotation pointer and watchdog registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= LW'(NUM_MASTERS - 1);
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Slave side: mux of the owner's request while BUSY, all zero while IDLE.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (busy) begin
      wbs_adr_o = wbm_adr_i[last_q*AW +: AW];
      wbs_dat_o = wbm_dat_i[last_q*DW +: DW];
      wbs_sel_o = wbm_sel_i[last_q*SW +: SW];
      wbs_we_o  = wbm_we_i[last_q];
      wbs_cyc_o = g_cyc;
      wbs_stb_o = g_stb & ~wd_fire;
      wbs_cti_o = wbm_cti_i[last_q*3 +: 3];
      wbs_bte_o = wbm_bte_i[last_q*2 +: 2];
    end
  end

  // Master side: read data broadcast, responses only to the owner.
  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_resp
    assign wbm_dat_o[m*DW +: DW] = wbs_dat_i;
    assign wbm_ack_o[m] = busy & grant_q[m] & wbs_ack_i;
    assign wbm_err_o[m] = busy & grant_q[m] & (wbs_err_i | wd_fire);
    assign wbm_rty_o[m] = busy & grant_q[m] & wbs_rty_i;
  end

endmodule

// File: doc/mpsoc_msi_wb_arbiter.md
Name: mpsoc_msi_wb_arbiter

Overview:
- Round-robin Wishbone arbiter that lets NUM_MASTERS requesters share one slave port: or1k data, or1k instruction and debug.
- Sits in front of the memory/UART decode of mpsoc_msi_wb_interface.
- Grants the bus for a whole cycle (cyc high), including classic and incrementing bursts.
- Runs a response watchdog that returns err to the master when the slave hangs.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (index 0 = or1k_d, 1 = or1k_i, 2 = dbg).
- AW, 32, address width.
- DW, 32, data width; byte-select width is DW/8.
- TIMEOUT, 255, cycles without ack/err/rty before a watchdog err; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbm_adr_i  in  NUM_MASTERS*AW  master addresses, master m in slice [m*AW +: AW].
- wbm_dat_i  in  NUM_MASTERS*DW  master write data.
- wbm_sel_i  in  NUM_MASTERS*DW/8  byte selects.
- wbm_we_i  in  NUM_MASTERS  write enables.
- wbm_cyc_i  in  NUM_MASTERS  cycle requests.
- wbm_stb_i  in  NUM_MASTERS  strobes.
- wbm_cti_i  in  NUM_MASTERS*3  cycle type.
- wbm_bte_i  in  NUM_MASTERS*2  burst type.
- wbm_dat_o  out  NUM_MASTERS*DW  read data (slave data broadcast to all masters).
- wbm_ack_o  out  NUM_MASTERS  ack, granted master only.
- wbm_err_o  out  NUM_MASTERS  err, granted master only (slave err OR watchdog).
- wbm_rty_o  out  NUM_MASTERS  rty, granted master only.
- wbs_adr_o  out  AW  slave address.
- wbs_dat_o  out  DW  slave write data.
- wbs_sel_o  out  DW/8  slave byte selects.
- wbs_we_o  out  1  slave write enable.
- wbs_cyc_o  out  1  slave cycle.
- wbs_stb_o  out  1  slave strobe.
- wbs_cti_o  out  3  slave cycle type.
- wbs_bte_o  out  2  slave burst type.
- wbs_dat_i  in  DW  slave read data.
- wbs_ack_i  in  1  slave ack.
- wbs_err_i  in  1  slave err.
- wbs_rty_i  in  1  slave rty.
- grant_o  out  NUM_MASTERS  registered one-hot grant; all zero when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- One clock (wb_clk_i); reset (wb_rst_i) is synchronous and active-high.
- Reset values:
  - state = IDLE, grant_o = 0, last = NUM_MASTERS-1 (so master 0 has top priority first), watchdog counter = 0, timeout_o = 0.
  - wbs_cyc_o = wbs_stb_o = 0; all wbm_ack_o/err_o/rty_o = 0.
  - wbs_adr_o/dat_o/sel_o/we_o/cti_o/bte_o = 0 while idle.
- IDLE:
  - If any wbm_cyc_i is set, select the first requester searching from last+1 upward, wrapping modulo NUM_MASTERS.
  - Register the one-hot grant, set last to that index, go to BUSY.
  - If no request, stay in IDLE.
- BUSY:
  - Slave outputs are combinational muxes of the granted master's inputs.
  - wbs_cyc_o = granted wbm_cyc_i; wbs_stb_o = granted wbm_stb_i AND NOT watchdog_fire.
  - Slave ack/err/rty route only to the granted master; other masters see 0.
- BUSY -> IDLE when the granted wbm_cyc_i is low. wbs_cyc_o falls in that same cycle and grant_o clears on the next edge.
- Latency:
  - Request at edge N (IDLE) gives grant_o and wbs_cyc_o at N+1.
  - Handover: owner drops cyc in cycle N, IDLE in N+1, next owner granted at N+2. This is a minimum one-cycle dead cycle.
- Requests arriving during BUSY wait; the grant is never pre-empted, including across cti=010 bursts and stb-low gaps.
- Simultaneous requests are resolved purely by rotation; a master that drops cyc before being granted is skipped.
- Watchdog:
  - Counter increments each BUSY cycle with wbs_stb_o high and no ack/err/rty.
  - Clears on any response, when stb is low, and in IDLE.
  - When the counter equals TIMEOUT-1 and no response arrives, watchdog_fire asserts: the granted wbm_err_o is forced 1 for exactly that cycle, wbs_stb_o is forced 0, timeout_o pulses, and the counter clears.
  - A slave ack in the firing cycle wins: no err is issued.
- ack, err and rty are never asserted to any master outside BUSY.
- Reset mid-transaction: next edge returns to IDLE with all outputs at their reset values; in-flight slave responses are ignored.

Test Plan:
- Master 1 alone reads 0x0000_0100, slave acks after 2 cycles with 0xDEAD_BEEF -> grant_o=010 one cycle after cyc, wbm_ack_o=010, wbm_dat_o slice1=0xDEAD_BEEF; IDLE again 1 cycle after cyc drops.
- All three masters assert cyc on the same cycle after reset, single-beat each -> grant order 0,1,2; one idle cycle between grants; no ack to non-granted masters.
- Master 0 finishes, then masters 0 and 2 request together -> master 2 is granted first (rotation from last=0, searching 1,2).
- Master 2 runs a 4-beat cti=010 burst while master 0 requests -> grant_o stays 100 for all 4 acks; master 0 is granted after master 2 drops cyc.
- TIMEOUT=8, slave never responds -> wbm_err_o pulses for the granted master and timeout_o=1 in the 8th stb cycle; wbs_stb_o=0 in that cycle. Repeat with TIMEOUT=0 -> no err after 1000 cycles.
- Assert wb_rst_i during burst beat 2 -> next edge: grant_o=0, wbs_cyc_o=0; master 0 is granted first on the first request after reset.
